// File: rtl/jtdd_sdram_pkg.sv
// Shared constants for the download-side SDRAM writer.
// Covers the SDRAM command encodings, the mode register value and the FSM state codes.
package jtdd_sdram_pkg;

  // {ncs, nras, ncas, nwe}
  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_NOP = 4'b0111,
    CMD_INH = 4'b1111
  } cmd_t;

  // burst length 1, sequential, CAS latency 2, burst write
  localparam logic [12:0] MRS_VAL = 13'h0020;
  localparam logic [12:0] A10_ALL = 13'h0400;

  localparam logic [3:0] ST_INIT_WAIT = 4'd0;
  localparam logic [3:0] ST_INIT_PRE  = 4'd1;
  localparam logic [3:0] ST_INIT_REF1 = 4'd2;
  localparam logic [3:0] ST_INIT_REF2 = 4'd3;
  localparam logic [3:0] ST_INIT_MRS  = 4'd4;
  localparam logic [3:0] ST_IDLE      = 4'd5;
  localparam logic [3:0] ST_ACT       = 4'd6;
  localparam logic [3:0] ST_WR        = 4'd7;
  localparam logic [3:0] ST_PRE       = 4'd8;
  localparam logic [3:0] ST_REF       = 4'd9;

endpackage

// File: rtl/jtdd_sdram_refcnt.sv
// Auto-refresh timer: raises pend once every REF_PERIOD enabled cycles.
// Requests that pile up before service collapse into a single pend.
module jtdd_sdram_refcnt #(
  parameter int REF_PERIOD = 750
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic pend
);

  localparam int CW = $clog2(REF_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_reg;

  // A new period ending on the clear cycle wins, so that request is not lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      pend    <= 1'b0;
    end else begin
      if (clr) pend <= 1'b0;
      if (en) begin
        if (cnt_reg == LAST) begin
          cnt_reg <= '0;
          pend    <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtdd_sdram_prog.sv
// Turns the ROM-download word stream into SDRAM ACT/WRITE/PRE sequences, and
// also runs SDRAM power-up initialisation and periodic auto-refresh.
module jtdd_sdram_prog
  import jtdd_sdram_pkg::*;
#(
  parameter int INIT_WAIT  = 9600,
  parameter int TRCD       = 2,
  parameter int TWR        = 2,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int REF_PERIOD = 750
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic        prog_rdy,
  output logic        ovf,
  output logic        init_done,
  output logic        sdram_cke,
  output logic        sdram_ncs,
  output logic        sdram_nras,
  output logic        sdram_ncas,
  output logic        sdram_nwe,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic        sdram_dqml,
  output logic        sdram_dqmh
);

  localparam logic [13:0] INIT_WAIT_C = 14'(INIT_WAIT);
  // Counters hold "cycles left"; runtime loads are one less than the init ones
  // so that ACT->WRITE->PRE->ready lands on +2/+2/+2 with the defaults.
  localparam logic [3:0] TRCD_C      = 4'(TRCD - 1);
  localparam logic [3:0] TWR_C       = 4'(TWR - 1);
  localparam logic [3:0] TRP_C       = 4'(TRP - 1);
  localparam logic [3:0] TRFC_C      = 4'(TRFC - 1);
  localparam logic [3:0] TRP_INIT_C  = 4'(TRP);
  localparam logic [3:0] TRFC_INIT_C = 4'(TRFC);
  localparam logic [3:0] MRS_WAIT_C  = 4'd1;

  logic [3:0]  state_reg;
  logic [3:0]  wcnt_reg;
  logic [13:0] icnt_reg;
  cmd_t        cmd_reg;
  logic [12:0] a_reg;
  logic [15:0] dq_reg;
  logic        dq_oe_reg;
  logic [1:0]  dqm_reg;
  logic        cke_reg;
  logic        rdy_reg;
  logic        ovf_reg;
  logic        done_reg;
  logic [21:0] addr_reg;
  logic [7:0]  data_reg;
  logic [1:0]  mask_reg;

  logic        ref_pend;
  logic        ref_clr;
  logic        wait_over;
  logic [12:0] row;
  logic [12:0] col;

  assign wait_over = (wcnt_reg == 4'd0);
  assign ref_clr   = (state_reg == ST_IDLE) && ref_pend;
  assign row       = addr_reg[21:9];
  assign col       = {4'b0000, addr_reg[8:0]};

  jtdd_sdram_refcnt #(
    .REF_PERIOD(REF_PERIOD)
  ) u_refcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (done_reg),
    .clr  (ref_clr),
    .pend (ref_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT_WAIT;
      wcnt_reg  <= 4'd0;
      icnt_reg  <= 14'd0;
      cmd_reg   <= CMD_INH;
      a_reg     <= 13'd0;
      dq_reg    <= 16'd0;
      dq_oe_reg <= 1'b0;
      dqm_reg   <= 2'b11;
      cke_reg   <= 1'b0;
      rdy_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
      addr_reg  <= 22'd0;
      data_reg  <= 8'd0;
      mask_reg  <= 2'b11;
    end else begin
      cmd_reg   <= CMD_NOP;
      dq_oe_reg <= 1'b0;
      dqm_reg   <= 2'b11;

      // Acceptance is judged on the registered ready, never the one rising now
      if (prog_we) begin
        if (rdy_reg) begin
          addr_reg <= prog_addr;
          data_reg <= prog_data;
          mask_reg <= prog_mask;
          rdy_reg  <= 1'b0;
        end else begin
          ovf_reg  <= 1'b1;
        end
      end

      if (!wait_over) wcnt_reg <= wcnt_reg - 4'd1;

      case (state_reg)
        ST_INIT_WAIT: begin
          cke_reg <= 1'b1;
          if (cke_reg) begin
            if (icnt_reg == INIT_WAIT_C) begin
              cmd_reg   <= CMD_PRE;
              a_reg     <= A10_ALL;
              wcnt_reg  <= TRP_INIT_C;
              state_reg <= ST_INIT_PRE;
            end else begin
              icnt_reg  <= icnt_reg + 14'd1;
            end
          end
        end
        ST_INIT_PRE: if (wait_over) begin
          cmd_reg   <= CMD_REF;
          wcnt_reg  <= TRFC_INIT_C;
          state_reg <= ST_INIT_REF1;
        end
        ST_INIT_REF1: if (wait_over) begin
          cmd_reg   <= CMD_REF;
          wcnt_reg  <= TRFC_INIT_C;
          state_reg <= ST_INIT_REF2;
        end
        ST_INIT_REF2: if (wait_over) begin
          cmd_reg   <= CMD_MRS;
          a_reg     <= MRS_VAL;
          wcnt_reg  <= MRS_WAIT_C;
          state_reg <= ST_INIT_MRS;
        end
        ST_INIT_MRS: if (wait_over) begin
          done_reg  <= 1'b1;
          rdy_reg   <= 1'b1;
          state_reg <= ST_IDLE;
        end
        ST_IDLE: begin
          // After init, ready low in IDLE means the holding register is full
          if (ref_pend) begin
            cmd_reg   <= CMD_REF;
            wcnt_reg  <= TRFC_C;
            state_reg <= ST_REF;
          end else if (!rdy_reg) begin
            cmd_reg   <= CMD_ACT;
            a_reg     <= row;
            wcnt_reg  <= TRCD_C;
            state_reg <= ST_ACT;
          end
        end
        ST_ACT: if (wait_over) begin
          cmd_reg   <= CMD_WR;
          a_reg     <= col;
          dq_reg    <= {data_reg, data_reg};
          dq_oe_reg <= 1'b1;
          dqm_reg   <= mask_reg;
          wcnt_reg  <= TWR_C;
          state_reg <= ST_WR;
        end
        ST_WR: if (wait_over) begin
          cmd_reg   <= CMD_PRE;
          a_reg     <= 13'd0;
          wcnt_reg  <= TRP_C;
          state_reg <= ST_PRE;
        end
        ST_PRE: if (wait_over) begin
          rdy_reg   <= 1'b1;
          state_reg <= ST_IDLE;
        end
        ST_REF: if (wait_over) begin
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_INIT_WAIT;
      endcase
    end
  end

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_reg;
  assign sdram_cke   = cke_reg;
  assign sdram_ba    = 2'b00;
  assign sdram_a     = a_reg;
  assign sdram_dq_o  = dq_reg;
  assign sdram_dq_oe = dq_oe_reg;
  assign sdram_dqmh  = dqm_reg[1];
  assign sdram_dqml  = dqm_reg[0];
  assign prog_rdy    = rdy_reg;
  assign ovf         = ovf_reg;
  assign init_done   = done_reg;

endmodule

// File: tb/tb_jtdd_sdram_prog.sv
// Directed bench for jtdd_sdram_prog: init timing, write sequence, overflow,
// refresh priority, async reset and a bulk run checked against an SDRAM model.
module tb_jtdd_sdram_prog;

  localparam int IW   = 40;
  localparam int RP   = 100;
  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 7;

  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_INH = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;
  logic        prog_we = 1'b0;
  logic        prog_rdy, ovf, init_done, sdram_cke;
  logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe, sdram_dqml, sdram_dqmh;
  logic [3:0]  cmd;

  assign cmd = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};

  jtdd_sdram_prog #(
    .INIT_WAIT(IW), .TRCD(TRCD), .TWR(TWR), .TRP(TRP), .TRFC(TRFC), .REF_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .prog_rdy(prog_rdy), .ovf(ovf), .init_done(init_done), .sdram_cke(sdram_cke),
    .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
    .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SDRAM model fed from the pins, plus refresh-interval tracking
  logic [15:0] sd_mem [logic [21:0]];
  logic [15:0] exp_mem [logic [21:0]];
  int  wr_seen = 0;
  int  ref_n = 0;
  bit  mon_ref_en = 1'b0;
  int  last_ref = -1;

  initial begin
    logic [12:0] act_row;
    logic [21:0] wa;
    logic [15:0] w;
    act_row = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmd == C_ACT) act_row = sdram_a;
        if (cmd == C_WR) begin
          wa = {act_row, sdram_a[8:0]};
          w  = sd_mem.exists(wa) ? sd_mem[wa] : 16'h0;
          if (!sdram_dqmh) w[15:8] = sdram_dq_o[15:8];
          if (!sdram_dqml) w[7:0]  = sdram_dq_o[7:0];
          sd_mem[wa] = w;
          wr_seen++;
        end
        if (cmd == C_REF && mon_ref_en) begin
          if (last_ref >= 0) check("ref_interval_ok", 32'((cyc - last_ref) <= RP + 7), 1);
          last_ref = cyc;
          ref_n++;
        end
      end
    end
  end

  task automatic wait_cmd(input logic [3:0] c, input string tag, output int t);
    t = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd == c) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic strobe(input logic [21:0] ad, input logic [7:0] d, input logic [1:0] m);
    prog_addr = ad; prog_data = d; prog_mask = m; prog_we = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd"},  cmd, C_INH);
    check({tag, "_cke"},  sdram_cke, 0);
    check({tag, "_a"},    sdram_a, 0);
    check({tag, "_oe"},   sdram_dq_oe, 0);
    check({tag, "_dqm"},  {sdram_dqmh, sdram_dqml}, 2'b11);
    check({tag, "_rdy"},  prog_rdy, 0);
    check({tag, "_ovf"},  ovf, 0);
    check({tag, "_done"}, init_done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; prog_we = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
  endtask

  // Releases reset and checks the init command train; d returns the init_done cycle.
  task automatic init_seq(input bit poke, output int d);
    int t0, t;
    rst_n = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    check("cke_rise", sdram_cke, 1);
    if (poke) begin
      strobe(22'h00010, 8'h77, 2'b00);
      check("ovf_init", ovf, 1);
    end
    wait_cmd(C_PRE, "init_pre", t);
    check("init_pre_t", t - t0, IW + 1);
    check("init_pre_a10", sdram_a[10], 1);
    wait_cmd(C_REF, "init_ref1", t);
    check("init_ref1_t", t - t0, IW + 4);
    wait_cmd(C_REF, "init_ref2", t);
    check("init_ref2_t", t - t0, IW + 12);
    wait_cmd(C_MRS, "init_mrs", t);
    check("init_mrs_t", t - t0, IW + 20);
    check("init_mrs_a", sdram_a, 13'h0020);
    check("init_done_early", init_done, 0);
    d = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (init_done) begin
        d = cyc;
        break;
      end
    end
    check("init_done_t", d - t0, IW + 22);
    check("init_rdy", prog_rdy, 1);
    if (!poke) check("init_ovf", ovf, 0);
  endtask

  initial begin
    int d, s, t, nwr, tref, tact, twr, trdy, got, wr_base;
    logic [12:0] arow, wcol;
    logic [15:0] wdq, ev;
    logic [1:0]  wdqm;
    logic [7:0]  idx, bd;
    logic [1:0]  bm;
    logic [21:0] ba;

    // Phase A: init, single write with overflow, first refresh, refresh priority
    do_reset();
    init_seq(1'b0, d);

    strobe(22'h12345, 8'hA5, 2'b10);
    check("rdy_fall", prog_rdy, 0);
    nwr = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      prog_we = 1'b0;
      if (cmd == C_WR) nwr++;
      case (k)
        1: begin
          check("act_cmd", cmd, C_ACT);
          check("act_row", sdram_a, 13'h091);
          check("act_ba", sdram_ba, 0);
          check("ovf_before", ovf, 0);
        end
        2: check("ovf_busy", ovf, 1);
        3: begin
          check("wr_cmd", cmd, C_WR);
          check("wr_col", sdram_a, 13'h145);
          check("wr_dq", sdram_dq_o, 16'hA5A5);
          check("wr_oe", sdram_dq_oe, 1);
          check("wr_dqm", {sdram_dqmh, sdram_dqml}, 2'b10);
        end
        4: check("oe_drop", sdram_dq_oe, 0);
        5: begin
          check("pre_cmd", cmd, C_PRE);
          check("pre_a10", sdram_a[10], 0);
        end
        6: check("rdy_still_low", prog_rdy, 0);
        7: check("rdy_rise", prog_rdy, 1);
        default: ;
      endcase
      if (k == 1) begin
        prog_addr = 22'h00777; prog_data = 8'h3C; prog_mask = 2'b00; prog_we = 1'b1;
      end
    end
    check("single_write", nwr, 1);
    $display("txn A1 addr 12345 data a5 mask 10, second strobe dropped");

    wait_cmd(C_REF, "first_ref", t);
    check("first_ref_t", t - d, RP + 1);

    s = d + 2 * RP;
    while (cyc < s - 1) @(negedge clk);
    strobe(22'h2ABCD, 8'h5A, 2'b01);
    check("coll_strobe_cyc", cyc, s);
    check("coll_accept", prog_rdy, 0);
    tref = -1; tact = -1; twr = -1; trdy = -1;
    arow = '0; wcol = '0; wdq = '0; wdqm = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (cmd == C_REF && tref < 0) tref = k;
      if (cmd == C_ACT && tact < 0) begin tact = k; arow = sdram_a; end
      if (cmd == C_WR && twr < 0) begin
        twr = k; wcol = sdram_a; wdq = sdram_dq_o; wdqm = {sdram_dqmh, sdram_dqml};
      end
      if (prog_rdy && trdy < 0) trdy = k;
    end
    check("coll_ref_t", tref, 1);
    check("coll_act_t", tact, 1 + TRFC + 1);
    check("coll_wr_t", twr, 11);
    check("coll_rdy_t", trdy, 15);
    check("coll_row", arow, 13'h155);
    check("coll_col", wcol, 13'h1CD);
    check("coll_dq", wdq, 16'h5A5A);
    check("coll_dqm", wdqm, 2'b01);
    $display("txn A2 addr 2abcd data 5a mask 01 behind refresh");

    // Phase B: asynchronous reset during WRITE, then init restarts
    strobe(22'h00001, 8'h11, 2'b00);
    wait_cmd(C_WR, "rstwr", t);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    $display("txn B reset asserted during WRITE");
    init_seq(1'b1, d);

    // Phase C: bulk writes against the pin-level SDRAM model
    do_reset();
    init_seq(1'b0, d);
    sd_mem.delete();
    wr_base = wr_seen;
    last_ref = -1;
    ref_n = 0;
    mon_ref_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      got = 0;
      for (int i = 0; i < 100 && got == 0; i++) begin
        if (prog_rdy) got = 1;
        else @(negedge clk);
      end
      if (got == 0) check("bulk_rdy_timeout", 0, 1);
      idx = 8'($urandom_range(0, 255));
      bd  = 8'($urandom);
      bm  = 2'($urandom_range(0, 3));
      ba  = {9'd0, idx[7:4], 5'd0, idx[3:0]};
      ev  = exp_mem.exists(ba) ? exp_mem[ba] : 16'h0;
      if (!bm[1]) ev[15:8] = bd;
      if (!bm[0]) ev[7:0]  = bd;
      exp_mem[ba] = ev;
      strobe(ba, bd, bm);
      $display("txn C%0d addr %h data %h mask %b", n, ba, bd, bm);
    end
    repeat (20) @(negedge clk);
    mon_ref_en = 1'b0;
    check("bulk_write_count", wr_seen - wr_base, 1000);
    check("bulk_ovf", ovf, 0);
    check("bulk_refreshed", 32'(ref_n > 0), 1);
    foreach (exp_mem[a]) begin
      ev = sd_mem.exists(a) ? sd_mem[a] : 16'h0;
      check("bulk_mem", ev, exp_mem[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
